// File: rtl/encoder_rpm_error_pkg.sv
// Shared widths, quadrature state codes and sign-magnitude helpers for encoder_rpm_error.
package encoder_rpm_error_pkg;

   localparam int unsigned N_WIDTH_DEF    = 17;
   localparam int unsigned Q_WIDTH_DEF    = 8;
   localparam int unsigned CNT_WIDTH_DEF  = 12;
   localparam int unsigned SM_MAG_MAX_DEF = (1 << (N_WIDTH_DEF - 1)) - 1;

   // Working widths of the helpers; word widths up to 31 bits are supported.
   localparam int unsigned SM_W   = 32;
   localparam int unsigned WIDE_W = 64;

   localparam logic [1:0] QS_00 = 2'b00;
   localparam logic [1:0] QS_01 = 2'b01;
   localparam logic [1:0] QS_11 = 2'b11;
   localparam logic [1:0] QS_10 = 2'b10;

   // Two's-complement count -> sign-magnitude Q(q_w) in an n_w-bit word, magnitude saturated.
   function automatic logic [SM_W-1:0] twos_to_sm(input logic signed [SM_W-1:0] cnt,
                                                  input int unsigned n_w,
                                                  input int unsigned q_w);
      logic              neg;
      logic [SM_W-1:0]   abs_cnt;
      logic [WIDE_W-1:0] mag_wide;
      logic [WIDE_W-1:0] mag_max;
      logic [SM_W-1:0]   res;
      neg      = cnt[SM_W-1];
      abs_cnt  = neg ? unsigned'(-cnt) : unsigned'(cnt);
      mag_wide = {{SM_W{1'b0}}, abs_cnt} << q_w;
      mag_max  = (WIDE_W'(1) << (n_w - 1)) - WIDE_W'(1);
      if (mag_wide > mag_max) mag_wide = mag_max;
      res = mag_wide[SM_W-1:0];
      if (neg && abs_cnt != '0) res = res | (SM_W'(1) << (n_w - 1));
      return res;
   endfunction

   // Sign-magnitude sp - meas with saturation; -0 inputs and results normalised to +0.
   function automatic logic [SM_W-1:0] sm_sub(input logic [SM_W-1:0] sp,
                                              input logic [SM_W-1:0] meas,
                                              input int unsigned n_w);
      logic [SM_W-1:0] mask;
      logic [SM_W-1:0] sbit;
      logic [SM_W-1:0] ma;
      logic [SM_W-1:0] mb;
      logic [SM_W-1:0] mag;
      logic            sa;
      logic            sb;
      logic            sr;
      sbit = SM_W'(1) << (n_w - 1);
      mask = sbit - SM_W'(1);
      ma   = sp & mask;
      mb   = meas & mask;
      sa   = ((sp & sbit) != '0) && (ma != '0);
      sb   = ((meas & sbit) != '0) && (mb != '0);
      if (sa == sb) begin
         if (ma >= mb) begin
            mag = ma - mb;
            sr  = sa;
         end else begin
            mag = mb - ma;
            sr  = !sa;
         end
      end else begin
         mag = ma + mb;
         if (mag > mask) mag = mask;
         sr = sa;
      end
      if (mag == '0) sr = 1'b0;
      return mag | (sr ? sbit : '0);
   endfunction

endpackage

// File: rtl/encoder_rpm_error_quad_decoder.sv
// Two-flop encoder synchronizer plus x4 quadrature decode with sticky illegal-jump flag.
module quad_decoder
   import encoder_rpm_error_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enc_a,
   input  logic enc_b,
   output logic up,
   output logic down,
   output logic fault
);

   logic [1:0] ab_meta;
   logic [1:0] ab_sync;
   logic [1:0] ab_prev;
   logic [1:0] fill;
   logic       primed;
   logic [1:0] fwd_c;
   logic [1:0] rev_c;
   logic       up_c;
   logic       down_c;
   logic       jump_c;

   // Expected neighbours of the previous state in each direction.
   always_comb begin
      fwd_c = QS_01;
      rev_c = QS_10;
      case (ab_prev)
         QS_00:   begin fwd_c = QS_01; rev_c = QS_10; end
         QS_01:   begin fwd_c = QS_11; rev_c = QS_00; end
         QS_11:   begin fwd_c = QS_10; rev_c = QS_01; end
         default: begin fwd_c = QS_00; rev_c = QS_11; end
      endcase
      up_c   = (ab_sync == fwd_c);
      down_c = (ab_sync == rev_c);
      jump_c = ((ab_sync ^ ab_prev) == 2'b11);
   end

   // fill tracks when ab_sync first carries a real sample; that sample only primes ab_prev.
   always_ff @(posedge clk) begin
      if (reset) begin
         ab_meta <= '0;
         ab_sync <= '0;
         ab_prev <= QS_00;
         fill    <= '0;
         primed  <= 1'b0;
         up      <= 1'b0;
         down    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         ab_meta <= {enc_a, enc_b};
         ab_sync <= ab_meta;
         fill    <= {fill[0], 1'b1};
         up      <= 1'b0;
         down    <= 1'b0;
         if (primed) begin
            up      <= up_c;
            down    <= down_c;
            ab_prev <= ab_sync;
            if (jump_c) fault <= 1'b1;
         end else if (fill[1]) begin
            ab_prev <= ab_sync;
            primed  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/encoder_rpm_error.sv
// Per-wheel speed measurement and setpoint error for the PI controller.
// Define MEAS_FILTER_EN to report the average of the current and previous window counts.
module encoder_rpm_error
   import encoder_rpm_error_pkg::*;
#(
   parameter int unsigned N_WIDTH   = N_WIDTH_DEF,
   parameter int unsigned Q_WIDTH   = Q_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic               CLOCK_50,
   input  logic               RESET,
   input  logic               ENC_A,
   input  logic               ENC_B,
   input  logic               SAMPLE_TICK,
   input  logic [N_WIDTH-1:0] SETPOINT,
   output logic [N_WIDTH-1:0] MEASURED,
   output logic [N_WIDTH-1:0] ERROR_K,
   output logic               ERROR_VALID,
   output logic               QUAD_FAULT
);

   localparam logic signed [CNT_WIDTH-1:0] CNT_MAX = {1'b0, {(CNT_WIDTH-1){1'b1}}};
   localparam logic signed [CNT_WIDTH-1:0] CNT_MIN = {1'b1, {(CNT_WIDTH-1){1'b0}}};

   logic                        up;
   logic                        down;
   logic                        fault;
   logic signed [CNT_WIDTH-1:0] count;
   logic signed [CNT_WIDTH-1:0] count_c;
   logic signed [CNT_WIDTH-1:0] meas_cnt_c;
   logic        [N_WIDTH-1:0]   meas_sm_c;
   logic        [N_WIDTH-1:0]   err_sm_c;
   logic        [N_WIDTH-1:0]   sp_hold;
   logic                        err_pending;

   quad_decoder u_quad_decoder (
      .clk   (CLOCK_50),
      .reset (RESET),
      .enc_a (ENC_A),
      .enc_b (ENC_B),
      .up    (up),
      .down  (down),
      .fault (fault)
   );

   assign QUAD_FAULT = fault;

   // Saturating count including this cycle's edge, so a tick-cycle edge lands in the old window.
   always_comb begin
      count_c = count;
      if (up && count != CNT_MAX) begin
         count_c = count + CNT_WIDTH'(1);
      end else if (down && count != CNT_MIN) begin
         count_c = count - CNT_WIDTH'(1);
      end
   end

`ifdef MEAS_FILTER_EN
   logic signed [CNT_WIDTH-1:0] prev_count;
   logic signed [CNT_WIDTH:0]   sum_c;

   assign sum_c      = (CNT_WIDTH+1)'(count_c) + (CNT_WIDTH+1)'(prev_count);
   assign meas_cnt_c = CNT_WIDTH'(sum_c >>> 1);

   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         prev_count <= '0;
      end else if (SAMPLE_TICK) begin
         prev_count <= count_c;
      end
   end
`else
   assign meas_cnt_c = count_c;
`endif

   assign meas_sm_c = N_WIDTH'(twos_to_sm(SM_W'(meas_cnt_c), N_WIDTH, Q_WIDTH));
   assign err_sm_c  = N_WIDTH'(sm_sub(SM_W'(sp_hold), SM_W'(MEASURED), N_WIDTH));

   // Tick edge: close window, register measurement and setpoint; next edge: register error.
   always_ff @(posedge CLOCK_50) begin
      if (RESET) begin
         count       <= '0;
         MEASURED    <= '0;
         sp_hold     <= '0;
         err_pending <= 1'b0;
         ERROR_K     <= '0;
         ERROR_VALID <= 1'b0;
      end else begin
         count       <= SAMPLE_TICK ? '0 : count_c;
         err_pending <= SAMPLE_TICK;
         ERROR_VALID <= err_pending;
         if (SAMPLE_TICK) begin
            MEASURED <= meas_sm_c;
            sp_hold  <= SETPOINT;
         end
         if (err_pending) ERROR_K <= err_sm_c;
      end
   end

endmodule

// File: tb/tb_encoder_rpm_error.sv
// Self-checking bench for encoder_rpm_error: vector table, corner sequences, random windows.
module tb_encoder_rpm_error;
   import encoder_rpm_error_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        enc_a;
   logic        enc_b;
   logic        tick;
   logic [16:0] sp;
   logic [16:0] meas;
   logic [16:0] err;
   logic        ev;
   logic        qf;

   int checks = 0;
   int errors = 0;
   int phase  = 0;
   int m_count = 0;
   int m_prev  = 0;

   typedef struct {
      int          edges;
      logic [16:0] sp;
      logic [16:0] meas;
      logic [16:0] err;
   } vec_t;

   vec_t tbl[7];

   always #5 clk = ~clk;

   encoder_rpm_error dut (
      .CLOCK_50    (clk),
      .RESET       (rst),
      .ENC_A       (enc_a),
      .ENC_B       (enc_b),
      .SAMPLE_TICK (tick),
      .SETPOINT    (sp),
      .MEASURED    (meas),
      .ERROR_K     (err),
      .ERROR_VALID (ev),
      .QUAD_FAULT  (qf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
      end
   endtask

   // ---- reference model: plain integer arithmetic on speeds ----
   function automatic int clamp(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [16:0] enc_sm(input int v);
      int m;
      m = (v < 0) ? -v : v;
      if (m > int'(SM_MAG_MAX_DEF)) m = int'(SM_MAG_MAX_DEF);
      return {(v < 0) && (m != 0), 16'(m)};
   endfunction

   function automatic int dec_sm(input logic [16:0] w);
      return w[16] ? -int'(w[15:0]) : int'(w[15:0]);
   endfunction

   function automatic int avg_floor(input int a, input int b);
      int s;
      s = a + b;
      return (s >= 0) ? s / 2 : -((1 - s) / 2);
   endfunction

   function automatic logic [1:0] ph_ab(input int p);
      case (p & 3)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic model_tick(input logic [16:0] spw, output logic [16:0] em, output logic [16:0] ee);
      int cur;
      int eff;
      cur     = m_count;
      m_count = 0;
`ifdef MEAS_FILTER_EN
      eff = avg_floor(cur, m_prev);
`else
      eff = cur;
`endif
      m_prev = cur;
      em = enc_sm(eff * 256);
      ee = enc_sm(dec_sm(spw) - dec_sm(em));
   endtask

   // ---- stimulus helpers ----
   task automatic move(input int dir);
      phase += dir;
      {enc_a, enc_b} = ph_ab(phase);
      m_count = clamp(m_count + dir, -2048, 2047);
   endtask

   task automatic edges(input int n, input int gap);
      int k;
      k = (n < 0) ? -n : n;
      for (int i = 0; i < k; i++) begin
         move((n < 0) ? -1 : 1);
         repeat (gap) step();
      end
   endtask

   task automatic settle();
      repeat (6) step();
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      tick = 1'b0;
      step();
      step();
      rst = 1'b0;
      m_count = 0;
      m_prev  = 0;
      settle();
   endtask

   task automatic tick_check(input string tag, input logic [16:0] spw);
      logic [16:0] em;
      logic [16:0] ee;
      sp   = spw;
      tick = 1'b1;
      model_tick(spw, em, ee);
      step();
      tick = 1'b0;
      chk({tag, "_meas"}, 32'(meas), 32'(em));
      chk({tag, "_ev_t1"}, 32'(ev), 0);
      step();
      chk({tag, "_ev_t2"}, 32'(ev), 1);
      chk({tag, "_err"}, 32'(err), 32'(ee));
      step();
      chk({tag, "_ev_t3"}, 32'(ev), 0);
      chk({tag, "_err_hold"}, 32'(err), 32'(ee));
   endtask

   initial begin
      logic [16:0] em1, ee1, em2, ee2;

`ifdef MEAS_FILTER_EN
      tbl[0] = '{40,   17'h03000, 17'h01400, 17'h01C00};
      tbl[1] = '{-25,  17'h00A00, 17'h00700, 17'h00300};
      tbl[2] = '{300,  17'h1C800, 17'h08900, 17'h1FFFF};
      tbl[3] = '{0,    17'h10000, 17'h09600, 17'h19600};
      tbl[4] = '{-3,   17'h10300, 17'h10200, 17'h10100};
      tbl[5] = '{40,   17'h02800, 17'h01200, 17'h01600};
      tbl[6] = '{20,   17'h01E00, 17'h01E00, 17'h00000};
`else
      tbl[0] = '{40,   17'h03000, 17'h02800, 17'h00800};
      tbl[1] = '{-25,  17'h00A00, 17'h11900, 17'h02300};
      tbl[2] = '{300,  17'h1C800, 17'h0FFFF, 17'h1FFFF};
      tbl[3] = '{0,    17'h10000, 17'h00000, 17'h00000};
      tbl[4] = '{-3,   17'h10300, 17'h10300, 17'h00000};
      tbl[5] = '{40,   17'h02800, 17'h02800, 17'h00000};
      tbl[6] = '{20,   17'h01E00, 17'h01400, 17'h00A00};
`endif

      enc_a = 1'b0;
      enc_b = 1'b0;
      tick  = 1'b0;
      sp    = '0;
      rst   = 1'b1;
      do_reset();
      chk("reset_meas", 32'(meas), 0);
      chk("reset_err",  32'(err),  0);
      chk("reset_ev",   32'(ev),   0);
      chk("reset_qf",   32'(qf),   0);

      // Vector table: edges in the window, setpoint, expected outputs.
      for (int i = 0; i < 7; i++) begin
         logic [16:0] em;
         logic [16:0] ee;
         int          gap;
         gap = (tbl[i].edges > 50 || tbl[i].edges < -50) ? 2 : 10;
         edges(tbl[i].edges, gap);
         settle();
         sp   = tbl[i].sp;
         tick = 1'b1;
         model_tick(sp, em, ee);
         step();
         tick = 1'b0;
         chk($sformatf("vec%0d_meas", i), 32'(meas), 32'(tbl[i].meas));
         chk($sformatf("vec%0d_ev_t1", i), 32'(ev), 0);
         step();
         chk($sformatf("vec%0d_ev_t2", i), 32'(ev), 1);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].err));
         step();
         chk($sformatf("vec%0d_ev_t3", i), 32'(ev), 0);
      end

      // Edge decoded in the very cycle of the tick belongs to the closing window.
      do_reset();
      edges(4, 10);
      move(1);
      step();
      step();
      step();
      tick_check("coinc_w1", 17'h00500);
      edges(3, 10);
      settle();
      tick_check("coinc_w2", 17'h00300);
      edges(2, 10);
      settle();
      tick_check("coinc_w3", 17'h00000);
`ifndef MEAS_FILTER_EN
      chk("coinc_w3_meas_sum", 32'(meas), 32'h00200);
`endif

      // Ticks on consecutive cycles: both windows reported, ERROR_VALID high twice.
      edges(6, 4);
      settle();
      sp   = 17'h00400;
      tick = 1'b1;
      model_tick(sp, em1, ee1);
      step();
      chk("b2b_meas1", 32'(meas), 32'(em1));
      chk("b2b_ev_a", 32'(ev), 0);
      sp = 17'h10100;
      model_tick(sp, em2, ee2);
      step();
      tick = 1'b0;
      chk("b2b_meas2", 32'(meas), 32'(em2));
      chk("b2b_ev_b", 32'(ev), 1);
      chk("b2b_err1", 32'(err), 32'(ee1));
      step();
      chk("b2b_ev_c", 32'(ev), 1);
      chk("b2b_err2", 32'(err), 32'(ee2));
      step();
      chk("b2b_ev_d", 32'(ev), 0);

      // Counter must saturate at +2047, not wrap negative.
      do_reset();
      edges(2100, 1);
      settle();
      tick_check("cnt_sat", 17'h00000);
      chk("cnt_sat_meas", 32'(meas), 32'h0FFFF);

      // Reset right after a tick drops the pending ERROR_VALID and clears outputs.
      edges(5, 4);
      settle();
      sp   = 17'h01000;
      tick = 1'b1;
      step();
      tick = 1'b0;
      rst  = 1'b1;
      step();
      rst  = 1'b0;
      m_count = 0;
      m_prev  = 0;
      chk("rst_mid_ev",   32'(ev),   0);
      chk("rst_mid_meas", 32'(meas), 0);
      chk("rst_mid_err",  32'(err),  0);
      chk("rst_mid_qf",   32'(qf),   0);
      step();
      chk("rst_mid_ev2",  32'(ev),   0);
      // Encoder sits at a non-zero state across reset; priming must not count it.
      settle();
      edges(7, 5);
      settle();
      tick_check("post_rst", 17'h00700);

      // Random windows against the model.
      for (int w = 0; w < 24; w++) begin
         int          n;
         int          gap;
         logic [16:0] spr;
         n = int'($urandom_range(0, 40));
         for (int e = 0; e < n; e++) begin
            gap = int'($urandom_range(1, 3));
            move(($urandom_range(0, 1) == 1) ? 1 : -1);
            repeat (gap) step();
         end
         settle();
         spr = 17'($urandom);
         if ($urandom_range(0, 5) == 0) spr[15:0] = 16'h0000;
         tick_check($sformatf("rnd%0d", w), spr);
      end

      // Illegal two-bit jump: no count, sticky fault until reset.
      do_reset();
      edges(3, 6);
      phase += 2;
      {enc_a, enc_b} = ph_ab(phase);
      settle();
      chk("fault_set", 32'(qf), 1);
      tick_check("fault_win", 17'h00300);
`ifndef MEAS_FILTER_EN
      chk("fault_err_zero", 32'(err), 32'h00000);
`endif
      edges(4, 5);
      settle();
      chk("fault_sticky", 32'(qf), 1);
      do_reset();
      chk("fault_cleared", 32'(qf), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
